// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch PC generator: FSM states, next-PC source codes
// and the instruction alignment mask helper.
package pc_gen_pkg;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_FENCE_WAIT = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP = 3'd0,
        SEL_MISP = 3'd1,
        SEL_EX   = 3'd2,
        SEL_HOLD = 3'd3,
        SEL_RAS  = 3'd4,
        SEL_PRED = 3'd5,
        SEL_SEQ  = 3'd6
    } pc_sel_e;

    // Clears the low log2(insn_bytes) bits; callers truncate to XLEN.
    function automatic logic [63:0] insn_align_mask(input int unsigned insn_bytes);
        return ~(64'(insn_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry; push+pop on a non-empty stack replaces the top in place.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign top_o   = mem_q[ptr_q];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            mem_d[ptr_q] = data_i;
        end else if (push_i) begin
            // ptr wraps onto the oldest slot once full, so overwrite is implicit
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = data_i;
            if (!full_o) cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: prioritised redirects, fetch handshake,
// fence-wait FSM and return-address prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSN_BYTES   = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready_i,
    input  logic            trap_redirect_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            mispredict_i,
    input  logic [XLEN-1:0] mispredict_pc_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] decode_pc_i,
    input  logic [XLEN-1:0] pred_offset_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            fence_i,
    input  logic            fence_done_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            ras_empty_o
);
    localparam logic [XLEN-1:0] ALIGN = XLEN'(insn_align_mask(INSN_BYTES));
    localparam logic [XLEN-1:0] STEP  = XLEN'(INSN_BYTES);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    pc_sel_e         sel;
    logic            advance, redirect;
    logic            ras_push, ras_pop, ras_clear, ras_full;
    logic [XLEN-1:0] ras_top;

    assign pc_o       = pc_q;
    assign pc_valid_o = (state_q == ST_RUN);
    assign advance    = pc_valid_o & fetch_ready_i & ~stall;
    assign redirect   = trap_redirect_i | mispredict_i | ex_redirect_i;

    always_comb begin
        state_d = state_q;
        sel     = SEL_HOLD;
        if (trap_redirect_i) begin
            sel     = SEL_TRAP;
            state_d = ST_RUN;
        end else if (mispredict_i) begin
            sel     = SEL_MISP;
            state_d = ST_RUN;
        end else if (ex_redirect_i) begin
            sel     = SEL_EX;
            state_d = ST_RUN;
        end else if (state_q == ST_FENCE_WAIT) begin
            if (fence_done_i) state_d = ST_RUN;
        end else if (!advance) begin
            sel = SEL_HOLD;
        end else if (fence_i) begin
            // fence_done_i is not sampled here, so a same-cycle done is ignored
            state_d = ST_FENCE_WAIT;
        end else if (ret_i && !ras_empty_o) begin
            sel = SEL_RAS;
        end else if (pred_taken_i) begin
            sel = SEL_PRED;
        end else begin
            sel = SEL_SEQ;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_TRAP: pc_d = trap_target_i & ALIGN;
            SEL_MISP: pc_d = mispredict_pc_i & ALIGN;
            SEL_EX:   pc_d = ex_target_i & ALIGN;
            SEL_RAS:  pc_d = ras_top & ALIGN;
            SEL_PRED: pc_d = (decode_pc_i + pred_offset_i) & ALIGN;
            SEL_SEQ:  pc_d = pc_q + STEP;
            default:  pc_d = pc_q;
        endcase
    end

    assign ras_clear = trap_redirect_i | mispredict_i;
    assign ras_push  = advance & ~redirect & pred_taken_i & call_i;
    assign ras_pop   = advance & ~redirect & ret_i;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .clear_i (ras_clear),
        .data_i  (decode_pc_i + STEP),
        .top_o   (ras_top),
        .empty_o (ras_empty_o),
        .full_o  (ras_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

endmodule
